// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered, blanked multiplex scanner for a 7-seg digit bank.
// Define SEG_LEADING_ZERO_BLANK_EN to hide digits above the highest non-zero code.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk_input,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   Enable,
  output logic [7:0]              SevenSeg,
  output logic                    frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = 6 * NUM_DIGITS;
  typedef enum logic {S_BLANK, S_ON} state_t;
  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic                  w_last, w_wrap, r_pend_valid, r_frame_done;
  logic [BW-1:0]         r_act, r_pend, w_act_nxt, w_in;
  logic [4*NUM_DIGITS-1:0] w_act_data;
  logic [NUM_DIGITS-1:0] w_act_en, w_act_dp, w_vis, r_enable;
  logic [7:0]            r_seg;
  logic [3:0]            w_code;

  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'h0: dec = 7'h3F; 4'h1: dec = 7'h06; 4'h2: dec = 7'h5B; 4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66; 4'h5: dec = 7'h6D; 4'h6: dec = 7'h7D; 4'h7: dec = 7'h27;
      4'h8: dec = 7'h7F; 4'h9: dec = 7'h6F; 4'hA: dec = 7'h77; 4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39; 4'hD: dec = 7'h5E; 4'hE: dec = 7'h79; default: dec = 7'h71;
    endcase
  endfunction

  assign w_in = {digit_data, digit_en, dp};
  assign {w_act_data, w_act_en, w_act_dp} = r_act;

  always_comb begin
    w_last      = r_cnt == CW'(SCAN_DIV - 1);
    w_wrap      = w_last && r_idx == IW'(NUM_DIGITS - 1);
    w_cnt_nxt   = w_last ? '0 : r_cnt + 1'b1;
    w_idx_nxt   = w_wrap ? '0 : r_idx + IW'(w_last);
    w_state_nxt = w_cnt_nxt < CW'(BLANK_CYCLES) ? S_BLANK : S_ON;
    w_act_nxt   = !w_wrap ? r_act : load ? w_in : r_pend_valid ? r_pend : r_act;
    w_code      = w_act_data[r_idx*4 +: 4];
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] r_lz_mask;
  // Mask keeps digit 0 and every digit at or below the highest non-zero code.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [BW-1:0] a);
    logic seen;
    seen    = 1'b0;
    lz_mask = NUM_DIGITS'(1);
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen       = seen || a[2*NUM_DIGITS + 4*i +: 4] != 4'h0;
      lz_mask[i] = seen;
    end
  endfunction
  always_ff @(posedge clk_input) begin
    if (!rst)
      r_lz_mask <= NUM_DIGITS'(1);
    else if (w_wrap)
      r_lz_mask <= lz_mask(w_act_nxt);
  end
  assign w_vis = w_act_en & r_lz_mask;
`else
  assign w_vis = w_act_en;
`endif

  always_ff @(posedge clk_input) begin
    if (!rst) begin
      r_state      <= BLANK_CYCLES == 0 ? S_ON : S_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_act        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_enable     <= '0;
      r_seg        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_act        <= w_act_nxt;
      r_pend       <= load ? w_in : r_pend;
      r_pend_valid <= !w_wrap && (r_pend_valid || load);
      r_frame_done <= w_wrap;
      r_enable     <= r_state == S_ON && w_vis[r_idx] ? NUM_DIGITS'(1) << r_idx : '0;
      r_seg        <= r_state == S_ON ? {w_act_dp[r_idx], dec(w_code)} : '0;
    end
  end

  assign Enable     = r_enable;
  assign SevenSeg   = r_seg;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized scenarios checked cycle by cycle against a frame-level model.
module tb_seg_scan_driver;
  localparam int ND = 8, SD = 8, BC = 2, FL = ND * SD;
  logic clk = 0, rst = 0, load = 0;
  logic [31:0] digit_data = 0;
  logic [7:0] digit_en = 0, dp = 0, Enable, SevenSeg;
  logic frame_done;
  int errors = 0, checks = 0;
  int m_pos;
  bit m_pv;
  logic [31:0] m_data, m_pdata;
  logic [7:0] m_en, m_dp, m_pen, m_pdp, e_en, e_seg;
  logic e_fd;
  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk_input(clk), .rst(rst), .digit_data(digit_data), .digit_en(digit_en), .dp(dp),
    .load(load), .Enable(Enable), .SevenSeg(SevenSeg), .frame_done(frame_done));

  // One clock: expected outputs come from the scan position and the displayed frame's data.
  task automatic step();
    int slot, off;
    bit lit, vis;
    if (!rst) begin
      m_pos = 0; m_pv = 0; m_data = 0; m_en = 0; m_dp = 0;
      m_pdata = 0; m_pen = 0; m_pdp = 0; e_en = 0; e_seg = 0; e_fd = 0;
    end else begin
      slot = m_pos / SD;
      off  = m_pos % SD;
      lit  = off >= BC;
      vis  = 1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      begin
        int h;
        h = 0;
        for (int i = 0; i < ND; i++) if (m_data[4*i +: 4] != 0) h = i;
        vis = slot <= h;
      end
`endif
      e_en  = (lit && m_en[slot] && vis) ? 8'(1 << slot) : 8'h00;
      e_seg = lit ? {m_dp[slot], dec_tab[m_data[4*slot +: 4]]} : 8'h00;
      e_fd  = m_pos == FL - 1;
      if (m_pos == FL - 1 && (load || m_pv)) begin
        {m_data, m_en, m_dp} = load ? {digit_data, digit_en, dp} : {m_pdata, m_pen, m_pdp};
        m_pv = 0;
      end else if (load) begin
        {m_pdata, m_pen, m_pdp} = {digit_data, digit_en, dp};
        m_pv = 1;
      end
      m_pos = (m_pos + 1) % FL;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 0; load = 1; digit_data = $urandom(); digit_en = 8'hFF; dp = $urandom();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({Enable, SevenSeg, frame_done} !== 17'h0) begin
        errors++;
        $display("FAIL reset cyc=%0d got en=%h seg=%h fd=%b want 0", c, Enable, SevenSeg, frame_done);
      end
    end
    rst = 1; load = 0; digit_data = 0; digit_en = 0; dp = 0;
    n = 0;
    do begin
      step();
      n++;
      checks++;
      if ({Enable, SevenSeg, frame_done} !== {e_en, e_seg, e_fd}) begin
        errors++;
        $display("FAIL reset_scan n=%0d got %h/%h/%b want %h/%h/%b", n, Enable, SevenSeg, frame_done, e_en, e_seg, e_fd);
      end
    end while (!frame_done && n < 100);
    checks++;
    if (n !== FL) begin
      errors++;
      $display("FAIL first_frame_done got %0d cycles want %0d", n, FL);
    end
  endtask

  task automatic test_patterns();
    int p;
    bit seen;
    seen = 0;
    digit_data = 32'h76543210; digit_en = 8'hFF; dp = 8'h01; load = 1;
    for (int c = 0; c < 2 * FL + 10; c++) begin
      p = m_pos;
      step();
      load = 0;
      checks++;
      if ({Enable, SevenSeg, frame_done} !== {e_en, e_seg, e_fd}) begin
        errors++;
        $display("FAIL patterns cyc=%0d got %h/%h/%b want %h/%h/%b", c, Enable, SevenSeg, frame_done, e_en, e_seg, e_fd);
      end
      if (seen && (p == 2 || p == 58)) begin
        checks++;
        if ({Enable, SevenSeg} !== (p == 2 ? 16'h01BF : 16'h8027)) begin
          errors++;
          $display("FAIL patterns_anchor pos=%0d got %h/%h", p, Enable, SevenSeg);
        end
      end
      if (frame_done) seen = 1;
    end
  endtask

  task automatic test_midframe_load();
    int p;
    bit seen, done;
    seen = 0; done = 0;
    for (int c = 0; c < 2 * FL + 30; c++) begin
      if (!done && m_pos == 20) begin
        digit_data = 32'hFFFFFFFF; load = 1; done = 1;
      end
      p = m_pos;
      step();
      load = 0;
      checks++;
      if ({Enable, SevenSeg, frame_done} !== {e_en, e_seg, e_fd}) begin
        errors++;
        $display("FAIL midframe cyc=%0d got %h/%h/%b want %h/%h/%b", c, Enable, SevenSeg, frame_done, e_en, e_seg, e_fd);
      end
      if (seen && p % SD >= BC) begin
        checks++;
        if (SevenSeg[6:0] !== 7'h71) begin
          errors++;
          $display("FAIL midframe_anchor pos=%0d got %h want 71", p, SevenSeg[6:0]);
        end
      end
      if (done && frame_done) seen = 1;
    end
  endtask

  task automatic test_double_and_boundary_load();
    int p;
    bit seen, bdone;
    seen = 0; bdone = 0;
    dp = 0;
    while (m_pos != 0) step();
    for (int c = 0; c < 3 * FL; c++) begin
      if (c == 10) begin digit_data = 32'h11111111; load = 1; end
      if (c == 30) begin digit_data = 32'h22222222; load = 1; end
      if (c > FL && !bdone && m_pos == FL - 1) begin
        digit_data = $urandom(); digit_en = 8'hFF; dp = $urandom(); load = 1; bdone = 1;
      end
      p = m_pos;
      step();
      load = 0;
      checks++;
      if ({Enable, SevenSeg, frame_done} !== {e_en, e_seg, e_fd}) begin
        errors++;
        $display("FAIL double_load cyc=%0d got %h/%h/%b want %h/%h/%b", c, Enable, SevenSeg, frame_done, e_en, e_seg, e_fd);
      end
      if (seen && !bdone && p % SD >= BC) begin
        checks++;
        if (SevenSeg !== 8'h5B) begin
          errors++;
          $display("FAIL double_load_anchor pos=%0d got %h want 5b", p, SevenSeg);
        end
      end
      if (c > 30 && frame_done) seen = 1;
    end
  endtask

  task automatic test_digit_en();
    int n;
    digit_data = $urandom(); digit_en = 8'b1010_1010; dp = $urandom(); load = 1;
    for (int c = 0; c < 2 * FL; c++) begin
      step();
      load = 0;
      checks++;
      if ({Enable, SevenSeg, frame_done} !== {e_en, e_seg, e_fd}) begin
        errors++;
        $display("FAIL digit_en cyc=%0d got %h/%h/%b want %h/%h/%b", c, Enable, SevenSeg, frame_done, e_en, e_seg, e_fd);
      end
    end
    n = 0;
    do begin step(); n++; end while (!frame_done && n < 100);
    n = 0;
    do begin step(); n++; end while (!frame_done && n < 100);
    checks++;
    if (n !== FL) begin
      errors++;
      $display("FAIL frame_length got %0d want %0d", n, FL);
    end
  endtask

  task automatic test_leading_zero();
    digit_data = 32'h00000305; digit_en = 8'hFF; dp = 0; load = 1;
    for (int c = 0; c < 4 * FL; c++) begin
      if (c == 2 * FL) begin digit_data = 0; load = 1; end
      step();
      load = 0;
      checks++;
      if ({Enable, SevenSeg, frame_done} !== {e_en, e_seg, e_fd}) begin
        errors++;
        $display("FAIL leading_zero cyc=%0d got %h/%h/%b want %h/%h/%b", c, Enable, SevenSeg, frame_done, e_en, e_seg, e_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 8 * FL; c++) begin
      rst = c != 300;
      load = $urandom_range(0, 9) == 0;
      digit_data = $urandom(); digit_en = $urandom(); dp = $urandom();
      step();
      checks++;
      if ({Enable, SevenSeg, frame_done} !== {e_en, e_seg, e_fd}) begin
        errors++;
        $display("FAIL random cyc=%0d got %h/%h/%b want %h/%h/%b", c, Enable, SevenSeg, frame_done, e_en, e_seg, e_fd);
      end
    end
    rst = 1; load = 0;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_midframe_load();
    test_double_and_boundary_load();
    test_digit_en();
    test_leading_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
